sid_bus_if: RTL and testbench

SID_BUS_IF -- requirements
Module: sid_bus_if

---
 rtl/sid_pkg.sv | 22 ++
 rtl/sync2.sv | 27 ++
 rtl/sid_bus_if.sv | 164 ++++++++++++++++
 tb/tb_sid_bus_if.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared definitions for the SID bus interface: read-only register map and FSM states.
package sid_pkg;

    localparam logic [4:0] ADDR_POTX = 5'h19;
    localparam logic [4:0] ADDR_POTY = 5'h1A;
    localparam logic [4:0] ADDR_OSC3 = 5'h1B;
    localparam logic [4:0] ADDR_ENV3 = 5'h1C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WRITE,
        ST_READ,
        ST_RELEASE
    } state_t;

    // 0x19 and above never reach the internal register file.
    function automatic logic is_ro_addr(input logic [4:0] addr);
        return addr >= ADDR_POTX;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bundle of asynchronous inputs; 2 cycles latency, no backpressure.
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sid_bus_if.sv
// External SID bus to internal register strobe bridge with decaying bus latch.
// Write reaches oWE 2 + SETTLE_CYCLES + 1 cycles after CSn falls; the external bus cannot be stalled.
module sid_bus_if
    import sid_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int DECAY_TICKS   = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkEn,
    input  logic       iCSn,
    input  logic       iRW,
    input  logic [4:0] iBusAddr,
    input  logic [7:0] iBusData,
    output logic [7:0] oBusData,
    output logic       oBusOE,
    input  logic [7:0] iPotX,
    input  logic [7:0] iPotY,
    input  logic [7:0] iOsc3,
    input  logic [7:0] iEnv3,
    output logic       oWE,
    output logic [4:0] oAddr,
    output logic [7:0] oData
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int DCW = $clog2(DECAY_TICKS + 1);

    logic [14:0]    w_sync;
    logic           w_cs_n;
    logic           w_rw;
    logic [4:0]     w_addr;
    logic [7:0]     w_data;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_capture;
    logic           w_settle_done;
    logic [SCW-1:0] r_settle_cnt;

    logic [4:0]     r_addr;
    logic [7:0]     r_data;
    logic [7:0]     r_bus_data;
    logic           r_oe;
    logic [7:0]     w_rd_mux;

    logic [7:0]     r_latch;
    logic [DCW-1:0] r_decay_cnt;
    logic           w_wr;

    // CSn idles high so reset must not look like the start of an access.
    sync2 #(
        .WIDTH   (15),
        .RST_VAL (15'h4000)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d ({iCSn, iRW, iBusAddr, iBusData}),
        .o_q (w_sync)
    );

    assign w_cs_n = w_sync[14];
    assign w_rw   = w_sync[13];
    assign w_addr = w_sync[12:8];
    assign w_data = w_sync[7:0];

    assign w_settle_done = (r_settle_cnt >= SCW'(SETTLE_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_n) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_cs_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_settle_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = w_rw ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE:   w_state_nxt = ST_RELEASE;
            ST_READ: begin
                if (w_cs_n) w_state_nxt = ST_IDLE;
            end
            ST_RELEASE: begin
                if (w_cs_n) w_state_nxt = ST_IDLE;
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_settle_cnt <= w_cs_n ? SCW'(0) : SCW'(1);
        end else if (r_state == ST_SETTLE && !w_cs_n && !w_settle_done) begin
            r_settle_cnt <= r_settle_cnt + SCW'(1);
        end
    end

    always_comb begin
        w_rd_mux = r_latch;
        case (w_addr)
            ADDR_POTX: w_rd_mux = iPotX;
            ADDR_POTY: w_rd_mux = iPotY;
            ADDR_OSC3: w_rd_mux = iOsc3;
            ADDR_ENV3: w_rd_mux = iEnv3;
            default:   w_rd_mux = r_latch;
        endcase
    end

    // Read data is frozen at entry so later address wiggles cannot disturb the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_bus_data <= '0;
            r_oe       <= 1'b0;
        end else if (w_capture) begin
            r_addr <= w_addr;
            r_data <= w_data;
            r_oe   <= w_rw;
            if (w_rw) r_bus_data <= w_rd_mux;
        end else if (r_state == ST_READ && w_cs_n) begin
            r_oe <= 1'b0;
        end
    end

    assign w_wr = (r_state == ST_WRITE);

    // A write in the same cycle as a tick takes priority over decay.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_latch     <= '0;
            r_decay_cnt <= '0;
        end else if (w_wr) begin
            r_latch     <= r_data;
            r_decay_cnt <= '0;
        end else begin
            if (clkEn && r_decay_cnt != DCW'(DECAY_TICKS)) r_decay_cnt <= r_decay_cnt + DCW'(1);
            if (r_decay_cnt == DCW'(DECAY_TICKS)) r_latch <= '0;
        end
    end

    assign oWE      = w_wr && !is_ro_addr(r_addr);
    assign oAddr    = r_addr;
    assign oData    = r_data;
    assign oBusOE   = r_oe;
    assign oBusData = r_bus_data;

endmodule

// File: tb/tb_sid_bus_if.sv
// Bench for sid_bus_if: vector table, hand sequences for decay/reset corners, random accesses vs model.
module tb_sid_bus_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clkEn = 1'b0;
    logic       iCSn = 1'b1;
    logic       iRW = 1'b1;
    logic [4:0] iBusAddr = '0;
    logic [7:0] iBusData = '0;
    logic [7:0] oBusData;
    logic       oBusOE;
    logic [7:0] iPotX = 8'h11;
    logic [7:0] iPotY = 8'h22;
    logic [7:0] iOsc3 = 8'h33;
    logic [7:0] iEnv3 = 8'hA5;
    logic       oWE;
    logic [4:0] oAddr;
    logic [7:0] oData;

    sid_bus_if dut (
        .clk      (clk),
        .rst      (rst),
        .clkEn    (clkEn),
        .iCSn     (iCSn),
        .iRW      (iRW),
        .iBusAddr (iBusAddr),
        .iBusData (iBusData),
        .oBusData (oBusData),
        .oBusOE   (oBusOE),
        .iPotX    (iPotX),
        .iPotY    (iPotY),
        .iOsc3    (iOsc3),
        .iEnv3    (iEnv3),
        .oWE      (oWE),
        .oAddr    (oAddr),
        .oData    (oData)
    );

    always #5 clk = ~clk;

    // 2 sync + SETTLE_CYCLES + 1 with the default SETTLE_CYCLES of 2.
    localparam int WR_LAT = 5;

    int checks = 0;
    int passed = 0;

    // Observations of one access.
    int         ob_we_cnt, ob_we_lat, ob_oe_cnt, ob_oe_first, ob_oe_last;
    logic [4:0] ob_we_addr;
    logic [7:0] ob_we_data, ob_rd;
    logic       ob_rd_stable;

    // Reference model state.
    logic [7:0] m_latch;

    typedef struct {
        logic       rw;
        logic [4:0] addr;
        logic [7:0] data;
        int         low;
        int         exp_we;
        logic       exp_oe;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [7:0] model_read(input logic [4:0] a);
        case (a)
            5'h19:   return iPotX;
            5'h1A:   return iPotY;
            5'h1B:   return iOsc3;
            5'h1C:   return iEnv3;
            default: return m_latch;
        endcase
    endfunction

    // CSn low for cycles 0..low-1; address/data and paddles are disturbed mid-access.
    task automatic run_access(input logic rw, input logic [4:0] a, input logic [7:0] d,
                              input int low, input logic ce);
        ob_we_cnt = 0; ob_we_lat = -1; ob_oe_cnt = 0; ob_oe_first = -1; ob_oe_last = -1;
        ob_we_addr = '0; ob_we_data = '0; ob_rd = '0; ob_rd_stable = 1'b1;
        for (int k = 0; k < low + 9; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                iRW = rw; iBusAddr = a; iBusData = d;
            end
            if (k == 6) begin
                iBusAddr = 5'($urandom); iBusData = 8'($urandom);
                iPotX = ~iPotX; iPotY = ~iPotY; iOsc3 = ~iOsc3; iEnv3 = ~iEnv3;
            end
            if (k == low + 8) begin
                iPotX = ~iPotX; iPotY = ~iPotY; iOsc3 = ~iOsc3; iEnv3 = ~iEnv3;
            end
            iCSn  = (k < low) ? 1'b0 : 1'b1;
            clkEn = ce;
            @(negedge clk);
            if (oWE) begin
                if (ob_we_cnt == 0) begin
                    ob_we_lat = k; ob_we_addr = oAddr; ob_we_data = oData;
                end
                ob_we_cnt++;
            end
            if (oBusOE) begin
                if (ob_oe_cnt == 0) begin
                    ob_oe_first = k; ob_rd = oBusData;
                end else if (oBusData !== ob_rd) begin
                    ob_rd_stable = 1'b0;
                end
                ob_oe_last = k;
                ob_oe_cnt++;
            end
        end
        clkEn = 1'b0;
    endtask

    task automatic check_access(input string tag, input int low, input logic [4:0] a,
                                input logic [7:0] d, input int exp_we, input logic exp_oe,
                                input logic [7:0] exp_rd);
        chk($sformatf("%s_we_count", tag), ob_we_cnt, exp_we);
        if (exp_we > 0) begin
            chk($sformatf("%s_we_latency", tag), ob_we_lat, WR_LAT);
            chk($sformatf("%s_we_addr", tag), ob_we_addr, a);
            chk($sformatf("%s_we_data", tag), ob_we_data, d);
        end
        chk($sformatf("%s_oe_seen", tag), ob_oe_cnt > 0, exp_oe);
        if (exp_oe) begin
            chk($sformatf("%s_rd_data", tag), ob_rd, exp_rd);
            chk($sformatf("%s_rd_stable", tag), ob_rd_stable, 1'b1);
            chk($sformatf("%s_oe_first", tag), ob_oe_first, WR_LAT);
            // synchronized CSn high 2 cycles after the raw rise, OE drops one later
            chk($sformatf("%s_oe_last", tag), ob_oe_last, low + 2);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk); #1; clkEn = 1'b1;
        end
        @(posedge clk); #1; clkEn = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int rs_we_cnt, rs_we_lat;
        logic [4:0] rs_addr;
        logic [7:0] rs_data;

        tbl[0]  = '{1'b1, 5'h05, 8'h00, 4, 0, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 5'h15, 8'h07, 6, 1, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 5'h0A, 8'h99, 2, 0, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 5'h1C, 8'h00, 5, 0, 1'b1, 8'hA5};
        tbl[4]  = '{1'b1, 5'h19, 8'h00, 4, 0, 1'b1, 8'h11};
        tbl[5]  = '{1'b1, 5'h1A, 8'h00, 4, 0, 1'b1, 8'h22};
        tbl[6]  = '{1'b1, 5'h1B, 8'h00, 6, 0, 1'b1, 8'h33};
        tbl[7]  = '{1'b0, 5'h1B, 8'h55, 5, 0, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 5'h1D, 8'h00, 4, 0, 1'b1, 8'h55};
        tbl[9]  = '{1'b1, 5'h07, 8'h00, 1, 0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 5'h00, 8'hFF, 4, 1, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 5'h1F, 8'h00, 7, 0, 1'b1, 8'hFF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oWE", oWE, 1'b0);
        chk("rst_oAddr", oAddr, 5'h00);
        chk("rst_oData", oData, 8'h00);
        chk("rst_oBusOE", oBusOE, 1'b0);
        chk("rst_oBusData", oBusData, 8'h00);
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            run_access(tbl[i].rw, tbl[i].addr, tbl[i].data, tbl[i].low, 1'b0);
            check_access($sformatf("vec%0d", i), tbl[i].low, tbl[i].addr, tbl[i].data,
                         tbl[i].exp_we, tbl[i].exp_oe, tbl[i].exp_rd);
        end

        // Decay boundary: 1999 ticks keep the latch, the 2000th clears it.
        run_access(1'b0, 5'h04, 8'h3C, 5, 1'b0);
        check_access("decay_wr", 5, 5'h04, 8'h3C, 1, 1'b0, 8'h00);
        ticks(1999);
        run_access(1'b1, 5'h04, 8'h00, 4, 1'b0);
        check_access("decay_1999", 4, 5'h04, 8'h00, 0, 1'b1, 8'h3C);
        ticks(1);
        repeat (2) @(posedge clk);
        run_access(1'b1, 5'h04, 8'h00, 4, 1'b0);
        check_access("decay_2000", 4, 5'h04, 8'h00, 0, 1'b1, 8'h00);

        // Decay counter is saturated here; a write under continuous ticks must still load.
        run_access(1'b0, 5'h06, 8'h5A, 5, 1'b1);
        check_access("wr_vs_tick", 5, 5'h06, 8'h5A, 1, 1'b0, 8'h00);
        run_access(1'b1, 5'h06, 8'h00, 4, 1'b0);
        check_access("wr_vs_tick_rd", 4, 5'h06, 8'h00, 0, 1'b1, 8'h5A);

        // Reset in the middle of settling; CSn stays low afterwards.
        rs_we_cnt = 0; rs_we_lat = -1; rs_addr = '0; rs_data = '0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                iRW = 1'b0; iBusAddr = 5'h12; iBusData = 8'h34;
            end
            iCSn = (k < 14) ? 1'b0 : 1'b1;
            rst  = (k == 3);
            @(negedge clk);
            if (k == 4) begin
                chk("rst_mid_oBusData", oBusData, 8'h00);
                chk("rst_mid_oWE", oWE, 1'b0);
            end
            if (oWE) begin
                if (rs_we_cnt == 0) begin
                    rs_we_lat = k; rs_addr = oAddr; rs_data = oData;
                end
                rs_we_cnt++;
            end
        end
        chk("rst_mid_we_count", rs_we_cnt, 1);
        chk("rst_mid_we_latency", rs_we_lat, 4 + WR_LAT);
        chk("rst_mid_we_addr", rs_addr, 5'h12);
        chk("rst_mid_we_data", rs_data, 8'h34);
        m_latch = 8'h34;

        for (int n = 0; n < 40; n++) begin
            logic       rw;
            logic [4:0] a;
            logic [7:0] d;
            int         low;
            logic       acc;
            int         exp_we;
            logic [7:0] exp_rd;
            rw  = 1'($urandom);
            a   = 5'($urandom);
            d   = 8'($urandom);
            low = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(4, 8);
            iPotX = 8'($urandom); iPotY = 8'($urandom);
            iOsc3 = 8'($urandom); iEnv3 = 8'($urandom);
            acc    = (low >= 4);
            exp_we = (acc && !rw && a < 5'h19) ? 1 : 0;
            exp_rd = model_read(a);
            run_access(rw, a, d, low, 1'b0);
            check_access($sformatf("rnd%0d", n), low, a, d, exp_we, acc && rw, exp_rd);
            if (acc && !rw) m_latch = d;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
